fifo_stream_drain: RTL and testbench

Downstream drain stage for the team's synchronous FIFO: issues `fifo_rd_en` only when the FIFO is non-empty, captures the FIFO's registered `data_out` one cycle later, and re-presents the words on a valid/ready stream through a 2-entry buffer. It also frames the stream, asserting `m_last` every FRAME_LEN words. By construction it never provokes FIFO underflow and never drops or duplicates a word.

---
 rtl/fifo_stream_drain.sv | 119 +++++++++++
 tb/tb_fifo_stream_drain.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain
//
// Drain stage that sits behind a synchronous FIFO with a registered data_out.
// It requests reads only when the FIFO is non-empty and a buffer slot is
// guaranteed. It captures each word one cycle after its read and presents the
// words on a valid/ready stream through a 2-entry buffer. m_last is asserted on
// every FRAME_LEN-th word, and frame_cnt counts completed frames.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   drain_en    permits new FIFO reads when high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after an accepted read
//   fifo_rd_en  read request to the FIFO (combinational)
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_data      output word (buffer head)
//   m_last      final word of the current frame
//   frame_cnt   number of completed frames, wraps at 16 bits
//   busy        buffer non-empty or a read in flight
// -----------------------------------------------------------------------------
module fifo_stream_drain #(
    parameter int FIFO_WIDTH = 8,
    parameter int FRAME_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    logic [FIFO_WIDTH-1:0] buf_reg [2];
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic                  head_reg;
    logic                  tail_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [15:0]           frame_cnt_reg;
    logic                  pop;
    logic [2:0]            credit;

    assign m_valid = (occ_reg != 2'd0);
    assign pop     = m_valid & m_ready;

    // Slots already committed: words held plus a word still on its way in.
    assign credit = {1'b0, occ_reg} + {2'b00, inflight_reg};

    // A read is allowed when a slot is free now, or when a slot frees this
    // cycle through a pop. The rst_n term holds the request low during reset.
    assign fifo_rd_en = rst_n & drain_en & ~fifo_empty &
                        ((credit < 3'd2) | ((credit == 3'd2) & pop));

    assign m_data    = buf_reg[head_reg];
    assign m_last    = m_valid & (idx_reg == IDX_LAST);
    assign frame_cnt = frame_cnt_reg;
    assign busy      = m_valid | inflight_reg;

    always_comb begin
        occ_next = occ_reg;
        case ({inflight_reg, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    // The credit rule guarantees the tail slot is free, so capture needs no
    // further qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (inflight_reg) begin
            buf_reg[tail_reg] <= fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg       <= 2'd0;
            inflight_reg  <= 1'b0;
            head_reg      <= 1'b0;
            tail_reg      <= 1'b0;
            idx_reg       <= '0;
            frame_cnt_reg <= 16'd0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en;
            if (inflight_reg) begin
                tail_reg <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
                if (idx_reg == IDX_LAST) begin
                    idx_reg       <= '0;
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_drain
//
// Bench for fifo_stream_drain. A behavioural FIFO (depth 16, registered
// data_out) feeds the design. Every accepted FIFO write pushes the expected
// word and its frame-end flag into a scoreboard queue. A separate monitor at
// the falling edge pops and compares each delivered word. The monitor also
// checks the read/credit rules every cycle. It compares the one-off values
// that the stimulus posts to it.
// -----------------------------------------------------------------------------
module tb_fifo_stream_drain;

    localparam int W         = 8;
    localparam int FRAME_LEN = 4;
    localparam int DEPTH     = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          drain_en;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data  = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [15:0]   frame_cnt;
    logic          busy;

    fifo_stream_drain #(
        .FIFO_WIDTH (W),
        .FRAME_LEN  (FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / check plumbing ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void post(string n, logic [31:0] a, logic [31:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endfunction

    // ---------------- behavioural upstream FIFO ----------------
    logic [W-1:0] fq[$];
    int           fifo_cnt   = 0;
    logic         wr_en      = 1'b0;
    logic [W-1:0] wr_data    = '0;
    int           rd_count   = 0;
    int           push_count = 0;
    bit           underflow  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            rd_count   = 0;
            push_count = 0;
            fifo_cnt   <= 0;
            fifo_empty <= 1'b1;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() == 0) begin
                    underflow = 1'b1;
                end else begin
                    fifo_data <= fq.pop_front();
                    rd_count++;
                end
            end
            if (wr_en && fq.size() < DEPTH) begin
                exp_t e;
                fq.push_back(wr_data);
                e.d = wr_data;
                e.l = ((push_count % FRAME_LEN) == FRAME_LEN - 1);
                exp_q.push_back(e);
                push_count++;
            end
            fifo_cnt   <= fq.size();
            fifo_empty <= (fq.size() == 0);
        end
    end

    // ---------------- monitor ----------------
    int           pops = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic         prev_l = 1'b0;

    function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endfunction

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (!rst_n) begin
            pops       = 0;
            prev_stall = 1'b0;
        end else begin
            cmp("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            cmp("underflow", 32'(underflow), 32'd0);
            cmp("busy", 32'(busy), 32'((rd_count - pops) != 0));
            cmp("credit_le_2", 32'((rd_count - pops) <= 2), 32'd1);
            if (prev_stall) begin
                cmp("hold_valid", 32'(m_valid), 32'd1);
                cmp("hold_data", 32'(m_data), 32'(prev_d));
                cmp("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    cmp("word_data", 32'(m_data), 32'(e.d));
                    cmp("word_last", 32'(m_last), 32'(e.l));
                    cmp("frame_cnt_at_pop", 32'(frame_cnt),
                        32'((pops / FRAME_LEN) & 16'hFFFF));
                end
                $display("POP data=%02h last=%0b frame_cnt=%0d", m_data, m_last, frame_cnt);
                pops++;
            end
            prev_stall = m_valid & ~m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((fifo_cnt != 0 || exp_q.size() != 0 || busy) && g < 500) begin
            step();
            g++;
        end
        if (g >= 500) post("drain_timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_rd;
        int first_v;
        int last_v;
        int nv;
        int base;
        bit wr_done;

        rst_n    = 1'b0;
        drain_en = 1'b1;
        m_ready  = 1'b1;
        repeat (3) step();
        post("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        post("rst_m_valid", 32'(m_valid), 32'd0);
        post("rst_m_data", 32'(m_data), 32'd0);
        post("rst_m_last", 32'(m_last), 32'd0);
        post("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        post("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Preload 0x01..0x08, then stream at full rate.
        drain_en = 1'b0;
        for (int i = 1; i <= 8; i++) wr(W'(i));
        step();
        drain_en = 1'b1;
        first_rd = -1;
        first_v  = -1;
        last_v   = -1;
        nv       = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                nv++;
            end
        end
        step();
        post("t1_latency", 32'(first_v - first_rd), 32'd2);
        post("t1_consecutive_span", 32'(last_v - first_v), 32'd7);
        post("t1_word_count", 32'(nv), 32'd8);
        wait_drain();
        post("t1_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure: only two reads may be issued while m_ready is low.
        drain_en = 1'b0;
        for (int i = 0; i < 6; i++) wr(W'(8'h11 + i));
        step();
        base     = rd_count;
        m_ready  = 1'b0;
        drain_en = 1'b1;
        repeat (10) step();
        post("t2_reads_issued", 32'(rd_count - base), 32'd2);
        post("t2_head_word", 32'(m_data), 32'h11);
        post("t2_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        wait_drain();
        post("t2_frame_cnt", 32'(frame_cnt), 32'd3);

        // Empty FIFO with random controls.
        for (int i = 0; i < 40; i++) begin
            drain_en = 1'($urandom_range(0, 1));
            m_ready  = 1'($urandom_range(0, 1));
            step();
        end

        // Frame spanning a drain_en gap.
        reset_pulse();
        drain_en = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 3; i++) wr(W'(8'h31 + i));
        wait_drain();
        drain_en = 1'b0;
        wr(8'h34);
        repeat (4) step();
        post("t4_gap_no_read", 32'(rd_count), 32'd3);
        drain_en = 1'b1;
        wait_drain();
        post("t4_frame_cnt", 32'(frame_cnt), 32'd1);

        // 64 random words with a concurrent writer and random m_ready.
        reset_pulse();
        wr_done = 1'b0;
        fork
            begin
                int n;
                n = 0;
                while (n < 64) begin
                    if ($urandom_range(0, 3) != 0 && fifo_cnt < DEPTH) begin
                        wr_en   = 1'b1;
                        wr_data = W'($urandom);
                        n++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    step();
                end
                wr_en   = 1'b0;
                wr_done = 1'b1;
            end
            begin
                int g;
                g = 0;
                step();
                while ((!wr_done || exp_q.size() != 0) && g < 3000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    step();
                    g++;
                end
                if (g >= 3000) post("t5_timeout", 32'd1, 32'd0);
                m_ready = 1'b1;
            end
        join
        wait_drain();
        post("t5_frame_cnt", 32'(frame_cnt), 32'd16);

        // Reset in the middle of a stalled transfer.
        drain_en = 1'b0;
        for (int i = 0; i < 6; i++) wr(W'(8'h51 + i));
        drain_en = 1'b1;
        m_ready  = 1'b0;
        repeat (4) step();
        post("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        post("t6_rst_m_valid", 32'(m_valid), 32'd0);
        post("t6_rst_busy", 32'(busy), 32'd0);
        post("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        post("t6_rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (3) step();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) wr(W'(8'hA0 + i));
        wait_drain();
        post("t6_frame_cnt", 32'(frame_cnt), 32'd1);

        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
